// File: rtl/store_buffer_pkg.sv
// Shared defaults and types for the posted-write store buffer.
// Imported by the top and the forwarding merge.
package store_buffer_pkg;

    localparam int unsigned SB_DEPTH  = 4;
    localparam int unsigned SB_ADDR_W = 32;
    localparam int unsigned SB_DATA_W = 32;
    localparam int unsigned SB_PTR_W  = $clog2(SB_DEPTH);
    localparam int unsigned SB_CNT_W  = SB_PTR_W + 1;

    // Current owner of the shared RAM port.
    typedef enum logic [1:0] {
        PORT_IDLE  = 2'd0,
        PORT_LOAD  = 2'd1,
        PORT_DRAIN = 2'd2
    } sb_port_e;

endpackage

// File: rtl/sb_fwd_merge.sv
// Per-lane load forwarding: walks the buffer from oldest to youngest so the
// youngest matching byte wins, falling back to RAM data.
module sb_fwd_merge
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH  = SB_DEPTH,
    parameter int unsigned WADR_W = 30,
    parameter int unsigned DATA_W = SB_DATA_W,
    parameter int unsigned SEL_W  = DATA_W / 8,
    parameter int unsigned PTR_W  = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]             valid_i,
    input  logic [DEPTH-1:0][WADR_W-1:0] wadr_i,
    input  logic [DEPTH-1:0][SEL_W-1:0]  sel_i,
    input  logic [DEPTH-1:0][DATA_W-1:0] data_i,
    input  logic [PTR_W-1:0]             head_i,
    input  logic [WADR_W-1:0]            ld_wadr_i,
    input  logic [DATA_W-1:0]            ram_data_i,
    output logic [DATA_W-1:0]            ld_data_o
);

    logic [PTR_W-1:0] idx;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        ld_data_o = ram_data_i;
        idx       = head_i;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_i + PTR_W'(k);
            if (valid_i[idx] && (wadr_i[idx] == ld_wadr_i)) begin
                for (int b = 0; b < SEL_W; b++) begin
                    if (sel_i[idx][b]) begin
                        ld_data_o[b*8 +: 8] = data_i[idx][b*8 +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between the mem stage and the data RAM: stores retire
// in one cycle, drain in order in the background, and are forwarded to loads.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH  = SB_DEPTH,
    parameter int unsigned ADDR_W = SB_ADDR_W,
    parameter int unsigned DATA_W = SB_DATA_W,
    parameter int unsigned SEL_W  = DATA_W / 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_ce_i,
    input  logic                     req_we_i,
    input  logic [ADDR_W-1:0]        req_addr_i,
    input  logic [SEL_W-1:0]         req_sel_i,
    input  logic [DATA_W-1:0]        req_data_i,
    input  logic                     sync_i,
    output logic [DATA_W-1:0]        ld_data_o,
    output logic                     stall_req_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    input  logic                     ram_ready_i,
    input  logic [DATA_W-1:0]        ram_data_i,
    output logic                     ram_ce_o,
    output logic                     ram_we_o,
    output logic [ADDR_W-1:0]        ram_addr_o,
    output logic [SEL_W-1:0]         ram_sel_o,
    output logic [DATA_W-1:0]        ram_data_o
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned OFF_W  = $clog2(SEL_W);
    localparam int unsigned WADR_W = ADDR_W - OFF_W;

    logic [PTR_W-1:0]             head_q, head_d, tail_q, tail_d, tail_m1;
    logic [CNT_W-1:0]             count_q, count_d;
    logic [DEPTH-1:0]             valid_q, valid_d;
    logic [DEPTH-1:0][WADR_W-1:0] wadr_q;
    logic [DEPTH-1:0][SEL_W-1:0]  sel_q;
    logic [DEPTH-1:0][DATA_W-1:0] data_q;

    logic [WADR_W-1:0] req_wadr;
    logic [DATA_W-1:0] merged;
    sb_port_e          port_sel;
    logic is_load, is_store, not_empty, pop, coalesce_hit, can_enq;
    logic load_stall, store_stall, sync_stall, stall, st_go, do_coal, do_enq;

    assign req_wadr  = req_addr_i[ADDR_W-1:OFF_W];
    assign is_load   = req_ce_i & ~req_we_i;
    assign is_store  = req_ce_i & req_we_i;
    assign not_empty = (count_q != '0);
    assign tail_m1   = tail_q - PTR_W'(1);

    always_comb begin
        if (rst)            port_sel = PORT_IDLE;
        else if (is_load)   port_sel = PORT_LOAD;
        else if (not_empty) port_sel = PORT_DRAIN;
        else                port_sel = PORT_IDLE;
    end

    assign pop = (port_sel == PORT_DRAIN) & ram_ready_i;

    // The head entry cannot absorb a store in the very cycle it leaves for RAM.
    assign coalesce_hit = not_empty & valid_q[tail_m1] & (wadr_q[tail_m1] == req_wadr)
                        & ~(pop & (tail_m1 == head_q));
    assign can_enq      = (count_q != CNT_W'(DEPTH)) | pop;

    assign load_stall  = is_load & ~ram_ready_i;
    assign store_stall = is_store & ~coalesce_hit & ~can_enq;
    assign sync_stall  = sync_i & not_empty;
    assign stall       = load_stall | store_stall | sync_stall;

    assign st_go   = is_store & ~stall;
    assign do_coal = st_go & coalesce_hit;
    assign do_enq  = st_go & ~coalesce_hit;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        valid_d = valid_q;
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end
        if (do_enq) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(do_enq) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // NOTE: the entry storage has no reset; valid_q and count_q alone say which entries are live.
    always_ff @(posedge clk) begin
        if (do_enq) begin
            wadr_q[tail_q] <= req_wadr;
            sel_q[tail_q]  <= req_sel_i;
            data_q[tail_q] <= req_data_i;
        end else if (do_coal) begin
            sel_q[tail_m1] <= sel_q[tail_m1] | req_sel_i;
            for (int b = 0; b < SEL_W; b++) begin
                if (req_sel_i[b]) begin
                    data_q[tail_m1][b*8 +: 8] <= req_data_i[b*8 +: 8];
                end
            end
        end
    end

    sb_fwd_merge #(
        .DEPTH  (DEPTH),
        .WADR_W (WADR_W),
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W),
        .PTR_W  (PTR_W)
    ) u_fwd_merge (
        .valid_i    (valid_q),
        .wadr_i     (wadr_q),
        .sel_i      (sel_q),
        .data_i     (data_q),
        .head_i     (head_q),
        .ld_wadr_i  (req_wadr),
        .ram_data_i (ram_data_i),
        .ld_data_o  (merged)
    );

    always_comb begin
        ram_ce_o   = 1'b0;
        ram_we_o   = 1'b0;
        ram_addr_o = '0;
        ram_sel_o  = '0;
        ram_data_o = '0;
        unique case (port_sel)
            PORT_LOAD: begin
                ram_ce_o   = 1'b1;
                ram_addr_o = req_addr_i;
                ram_sel_o  = req_sel_i;
            end
            PORT_DRAIN: begin
                ram_ce_o   = 1'b1;
                ram_we_o   = 1'b1;
                ram_addr_o = ADDR_W'(wadr_q[head_q]) << OFF_W;
                ram_sel_o  = sel_q[head_q];
                ram_data_o = data_q[head_q];
            end
            PORT_IDLE: begin
                ram_ce_o = 1'b0;
            end
        endcase
    end

    assign ld_data_o   = rst ? '0 : merged;
    assign stall_req_o = ~rst & stall;
    assign empty_o     = rst | ~not_empty;
    assign count_o     = rst ? '0 : count_q;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a queue model of buffered stores;
// drains are popped from the queue and compared as the DUT presents them.
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk, rst;
    logic        req_ce_i, req_we_i, sync_i, ram_ready_i;
    logic [31:0] req_addr_i, req_data_i, ram_data_i;
    logic [3:0]  req_sel_i;
    logic [31:0] ld_data_o, ram_addr_o, ram_data_o;
    logic        stall_req_o, empty_o, ram_ce_o, ram_we_o;
    logic [2:0]  count_o;
    logic [3:0]  ram_sel_o;

    store_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_ce_i(req_ce_i), .req_we_i(req_we_i), .req_addr_i(req_addr_i),
        .req_sel_i(req_sel_i), .req_data_i(req_data_i), .sync_i(sync_i),
        .ld_data_o(ld_data_o), .stall_req_o(stall_req_o), .empty_o(empty_o),
        .count_o(count_o), .ram_ready_i(ram_ready_i), .ram_data_i(ram_data_i),
        .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
        .ram_sel_o(ram_sel_o), .ram_data_o(ram_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [29:0] wadr;
        logic [3:0]  sel;
        logic [31:0] data;
    } ent_t;

    ent_t mq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic p_ld, p_st, p_pop, p_coal, p_stall;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mask_of(input logic [3:0] s);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{s[b]}};
        return m;
    endfunction

    function automatic logic [31:0] model_load(input logic [29:0] wa, input logic [31:0] rd);
        logic [31:0] r;
        r = rd;
        for (int i = 0; i < mq.size(); i++)
            if (mq[i].wadr == wa)
                for (int b = 0; b < 4; b++)
                    if (mq[i].sel[b]) r[b*8 +: 8] = mq[i].data[b*8 +: 8];
        return r;
    endfunction

    task automatic set_idle(input logic rdy);
        req_ce_i = 0; req_we_i = 0; req_addr_i = '0; req_sel_i = '0;
        req_data_i = '0; ram_data_i = '0; sync_i = 0; ram_ready_i = rdy;
    endtask

    task automatic set_st(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d, input logic rdy);
        set_idle(rdy);
        req_ce_i = 1; req_we_i = 1; req_addr_i = a; req_sel_i = s; req_data_i = d;
    endtask

    task automatic set_ld(input logic [31:0] a, input logic [3:0] s, input logic [31:0] rd, input logic rdy);
        set_idle(rdy);
        req_ce_i = 1; req_addr_i = a; req_sel_i = s; ram_data_i = rd;
    endtask

    // Predict this cycle from the model, then compare the settled outputs.
    task automatic eval_cycle(input string tag);
        int n;
        n       = mq.size();
        p_ld    = req_ce_i & ~req_we_i;
        p_st    = req_ce_i & req_we_i;
        p_pop   = !p_ld && n > 0 && ram_ready_i;
        p_coal  = p_st && n > 0 && mq[n-1].wadr == req_addr_i[31:2] && !(p_pop && n == 1);
        p_stall = (p_ld && !ram_ready_i) || (p_st && !p_coal && n == DEPTH && !p_pop)
                || (sync_i && n > 0);
        #1;
        if (rst) begin
            check({tag, ".rst_count"}, 64'(count_o), 64'd0);
            check({tag, ".rst_empty"}, 64'(empty_o), 64'd1);
            check({tag, ".rst_outs"}, {stall_req_o, ram_ce_o, ram_we_o, ram_sel_o}, 64'd0);
            check({tag, ".rst_data"}, {ld_data_o, ram_addr_o | ram_data_o}, 64'd0);
        end else begin
            check({tag, ".count"}, 64'(count_o), 64'(n));
            check({tag, ".empty"}, 64'(empty_o), 64'(n == 0));
            check({tag, ".stall"}, 64'(stall_req_o), 64'(p_stall));
            check({tag, ".ram_ce"}, 64'(ram_ce_o), 64'(p_ld || n > 0));
            check({tag, ".ram_we"}, 64'(ram_we_o), 64'(!p_ld && n > 0));
            if (p_ld) begin
                check({tag, ".ld_addr"}, 64'(ram_addr_o), 64'(req_addr_i));
                check({tag, ".ld_data"}, 64'(ld_data_o), 64'(model_load(req_addr_i[31:2], ram_data_i)));
            end else if (n > 0) begin
                check({tag, ".wr_addr"}, 64'(ram_addr_o), 64'({mq[0].wadr, 2'b00}));
                check({tag, ".wr_sel"}, 64'(ram_sel_o), 64'(mq[0].sel));
                check({tag, ".wr_data"}, 64'(ram_data_o & mask_of(mq[0].sel)),
                      64'(mq[0].data & mask_of(mq[0].sel)));
            end
        end
    endtask

    task automatic tick();
        ent_t e;
        @(posedge clk);
        if (rst) begin
            mq.delete();
        end else begin
            if (p_st && !p_stall && p_coal) begin
                e = mq[mq.size()-1];
                e.sel = e.sel | req_sel_i;
                for (int b = 0; b < 4; b++)
                    if (req_sel_i[b]) e.data[b*8 +: 8] = req_data_i[b*8 +: 8];
                mq[mq.size()-1] = e;
            end
            if (p_pop) void'(mq.pop_front());
            if (p_st && !p_stall && !p_coal) begin
                e.wadr = req_addr_i[31:2]; e.sel = req_sel_i; e.data = req_data_i;
                mq.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic step(input string tag);
        eval_cycle(tag);
        tick();
    endtask

    task automatic drain_all(input string tag);
        int guard;
        guard = 0;
        set_idle(1);
        while (mq.size() > 0 && guard < 16) begin
            step(tag);
            guard++;
        end
        check({tag, ".drained"}, 64'(mq.size()), 64'd0);
    endtask

    int n_stall;
    logic hi;

    initial begin
        set_idle(0);
        rst = 1;
        @(negedge clk);
        step("reset0");
        step("reset1");
        rst = 0;

        // Single store, then background drain.
        set_st(32'h100, 4'hF, 32'h11223344, 1);
        eval_cycle("t1_st");
        check("t1_no_stall", 64'(stall_req_o), 64'd0);
        tick();
        set_idle(1);
        eval_cycle("t1_drain");
        check("t1_wr", {ram_we_o, ram_addr_o, ram_data_o[30:0]}, {1'b1, 32'h100, 31'h11223344});
        tick();
        eval_cycle("t1_after");
        check("t1_empty", 64'(empty_o), 64'd1);
        tick();

        // Partial store forwarded over RAM data.
        set_st(32'h100, 4'h3, 32'h0000AABB, 0);
        step("t2_st");
        set_ld(32'h100, 4'hF, 32'hDEADBEEF, 1);
        eval_cycle("t2_ld");
        check("t2_fwd", 64'(ld_data_o), 64'hDEADAABB);
        tick();
        set_ld(32'h100, 4'hF, 32'hDEADBEEF, 0);
        step("t2_ld_stall");
        drain_all("t2_drain");

        // Youngest-first merge and coalescing only into the tail.
        set_st(32'h200, 4'hF, 32'h44332211, 0); step("t3_a");
        set_st(32'h204, 4'hF, 32'h55667788, 0); step("t3_b");
        set_st(32'h200, 4'hC, 32'hCC000000, 0); step("t3_c");
        set_st(32'h200, 4'h1, 32'h000000EE, 0);
        eval_cycle("t3_coal");
        check("t3_count", 64'(count_o), 64'd3);
        tick();
        set_ld(32'h200, 4'hF, 32'h0, 1);
        eval_cycle("t3_ld200");
        check("t3_youngest", 64'(ld_data_o), 64'hCC0022EE);
        check("t3_count_after_coal", 64'(count_o), 64'd3);
        tick();
        set_ld(32'h204, 4'hF, 32'hFFFFFFFF, 1); step("t3_ld204");
        drain_all("t3_drain");

        // Full buffer: fifth store stalls, then goes in alongside a pop.
        for (int i = 0; i < DEPTH; i++) begin
            set_st(32'h300 + 32'(4 * i), 4'hF, 32'hA0000000 + 32'(i), 0);
            step("t4_fill");
        end
        set_st(32'h310, 4'hF, 32'hA0000004, 0);
        eval_cycle("t4_full");
        check("t4_stall", 64'(stall_req_o), 64'd1);
        tick();
        set_st(32'h310, 4'hF, 32'hA0000004, 1);
        eval_cycle("t4_pop_push");
        check("t4_accept", 64'(stall_req_o), 64'd0);
        tick();
        set_idle(0);
        eval_cycle("t4_hold");
        check("t4_count", 64'(count_o), 64'd4);
        tick();
        drain_all("t4_drain");

        // Same word as a head that is popping: must enqueue, not coalesce.
        set_st(32'h400, 4'hF, 32'h01020304, 0); step("t4b_a");
        set_st(32'h400, 4'h1, 32'h000000FF, 1); step("t4b_b");
        drain_all("t4b_drain");

        // Load wins the port over a pending drain.
        set_st(32'h500, 4'hF, 32'h5A5A5A5A, 0); step("t5_st");
        set_ld(32'h600, 4'hF, 32'h12345678, 1);
        eval_cycle("t5_ld");
        check("t5_port", {ram_we_o, ram_addr_o}, {1'b0, 32'h600});
        tick();
        set_idle(1);
        eval_cycle("t5_drain");
        check("t5_late_wr", {ram_we_o, ram_addr_o}, {1'b1, 32'h500});
        tick();

        // sync_i stalls for exactly as many cycles as entries remain.
        for (int i = 0; i < 3; i++) begin
            set_st(32'h800 + 32'(8 * i), 4'hF, 32'h0BAD0000 + 32'(i), 0);
            step("t6_fill");
        end
        set_idle(1);
        sync_i = 1;
        n_stall = 0;
        for (int i = 0; i < 8; i++) begin
            eval_cycle("t6_sync");
            hi = stall_req_o;
            if (hi) n_stall++;
            tick();
            if (!hi) break;
        end
        check("t6_sync_cycles", 64'(n_stall), 64'd3);
        sync_i = 0;

        // Reset in the middle of a drain discards everything.
        set_st(32'h700, 4'hF, 32'h77777777, 0); step("t7_a");
        set_st(32'h704, 4'hF, 32'h88888888, 0); step("t7_b");
        set_idle(1); step("t7_drain");
        rst = 1;
        step("t7_rst");
        rst = 0;
        eval_cycle("t7_post");
        check("t7_cleared", {count_o, ram_ce_o}, 4'b0000);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
